// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family.
// Contents: default width/depth constants and the count-width helper used by
// the FIFO top level and by anything that models or drives it.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_W_DEF = 8;
  localparam int unsigned FIFO_DEPTH_DEF  = 16;

  // Occupancy counter width: one extra bit so the value DEPTH is representable.
  function automatic int unsigned fifo_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// Simple dual-port storage array for the synchronous FIFO.
// Ports:
//   clk, rst        - clock, async active-high reset (read register only)
//   we, waddr, wdata - synchronous write port
//   re, raddr, rdata - registered read port; rdata holds when re is low
// Kept as a separate block so a vendor RAM macro can replace it.
module fifo_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       re,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array: written only, never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; a same-address write in this cycle returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule : fifo_ram

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags and overflow/underflow error pulses.
// Ports:
//   clk, rst          - clock, async active-high reset
//   we, data_in       - write request and data
//   re, data_out      - read request and registered read data
//   full, empty       - count == DEPTH / count == 0
//   almost_full       - count >= AF_LEVEL
//   almost_empty      - count <= AE_LEVEL
//   count             - current occupancy, $clog2(DEPTH)+1 bits
//   overflow          - one-cycle pulse after a rejected write
//   underflow         - one-cycle pulse after a rejected read
// All outputs are registered; flags track the post-edge occupancy.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = FIFO_DATA_W_DEF,
  parameter int unsigned DEPTH    = FIFO_DEPTH_DEF,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          re,
  output logic [DATA_W-1:0]             data_out,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [fifo_cnt_w(DEPTH)-1:0]  count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = fifo_cnt_w(DEPTH);

  // Reject illegal configurations at elaboration.
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two and >= 4");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("fifo_sync_param: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_param: AE_LEVEL must be in 0..DEPTH-1");
  end
  if (DATA_W < 1) begin : g_bad_w
    $error("fifo_sync_param: DATA_W must be >= 1");
  end

  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             full_nxt, empty_nxt, af_nxt, ae_nxt;
  logic             ovf_nxt, unf_nxt;
  logic             wa, ra;

  // Accept decisions, pointer/count next state and next-state flags.
  always_comb begin
    wa         = 1'b0;
    ra         = 1'b0;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    cnt_nxt    = count;

    // A full FIFO can still take a write when a read frees a slot this cycle;
    // an empty FIFO never reads, even alongside a write (no fall-through).
    wa = we & (~full | re);
    ra = re & ~empty;

    if (wa) begin
      wr_ptr_nxt = wr_ptr + PTR_W'(1);
    end
    if (ra) begin
      rd_ptr_nxt = rd_ptr + PTR_W'(1);
    end

    unique case ({wa, ra})
      2'b10:   cnt_nxt = count + CNT_W'(1);
      2'b01:   cnt_nxt = count - CNT_W'(1);
      default: cnt_nxt = count;
    endcase

    full_nxt  = (cnt_nxt == CNT_W'(DEPTH));
    empty_nxt = (cnt_nxt == CNT_W'(0));
    af_nxt    = (cnt_nxt >= CNT_W'(AF_LEVEL));
    ae_nxt    = (cnt_nxt <= CNT_W'(AE_LEVEL));
    ovf_nxt   = we & ~wa;
    unf_nxt   = re & ~ra;
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= cnt_nxt;
      full         <= full_nxt;
      empty        <= empty_nxt;
      almost_full  <= af_nxt;
      almost_empty <= ae_nxt;
      overflow     <= ovf_nxt;
      underflow    <= unf_nxt;
    end
  end

  // Storage; its registered read port is data_out directly.
  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wa),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (ra),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

endmodule : fifo_sync_param

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: a default 8-bit/16-deep instance
// for directed fill/drain/corner cases, and a 12-bit/4-deep instance
// exercised against a reference queue.
module tb_fifo_sync_param;
  import fifo_pkg::*;

  localparam int unsigned DW_A  = FIFO_DATA_W_DEF;
  localparam int unsigned DP_A  = FIFO_DEPTH_DEF;
  localparam int unsigned CW_A  = fifo_cnt_w(DP_A);
  localparam int unsigned DW_B  = 12;
  localparam int unsigned DP_B  = 4;
  localparam int unsigned CW_B  = fifo_cnt_w(DP_B);
  localparam int unsigned AF_B  = 3;
  localparam int unsigned AE_B  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic            rst_a = 1'b1;
  logic            we_a = 1'b0, re_a = 1'b0;
  logic [DW_A-1:0] din_a = '0, dout_a;
  logic            full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic [CW_A-1:0] cnt_a;

  // Instance B signals
  logic            rst_b = 1'b1;
  logic            we_b = 1'b0, re_b = 1'b0;
  logic [DW_B-1:0] din_b = '0, dout_b;
  logic            full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic [CW_B-1:0] cnt_b;

  fifo_sync_param u_dut_a (
    .clk          (clk),
    .rst          (rst_a),
    .we           (we_a),
    .data_in      (din_a),
    .re           (re_a),
    .data_out     (dout_a),
    .full         (full_a),
    .empty        (empty_a),
    .almost_full  (af_a),
    .almost_empty (ae_a),
    .count        (cnt_a),
    .overflow     (ovf_a),
    .underflow    (unf_a)
  );

  fifo_sync_param #(
    .DATA_W   (DW_B),
    .DEPTH    (DP_B),
    .AF_LEVEL (AF_B),
    .AE_LEVEL (AE_B)
  ) u_dut_b (
    .clk          (clk),
    .rst          (rst_b),
    .we           (we_b),
    .data_in      (din_b),
    .re           (re_b),
    .data_out     (dout_b),
    .full         (full_b),
    .empty        (empty_b),
    .almost_full  (af_b),
    .almost_empty (ae_b),
    .count        (cnt_b),
    .overflow     (ovf_b),
    .underflow    (unf_b)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_flags(input string tag, input int unsigned c);
    check({tag, ".count"}, 32'(cnt_a), 32'(c));
    check({tag, ".full"},  32'(full_a),  32'(c == DP_A));
    check({tag, ".empty"}, 32'(empty_a), 32'(c == 0));
    check({tag, ".af"},    32'(af_a),    32'(c >= 14));
    check({tag, ".ae"},    32'(ae_a),    32'(c <= 2));
  endtask

  logic [DW_B-1:0] q[$];
  logic [DW_B-1:0] exp_dout_b;

  initial begin
    // Reset values
    tick();
    tick();
    check_a_flags("rst", 0);
    check("rst.dout", 32'(dout_a), 32'h0);
    check("rst.ovf",  32'(ovf_a),  32'h0);
    check("rst.unf",  32'(unf_a),  32'h0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();

    // Fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      we_a  = 1'b1;
      din_a = DW_A'(i);
      tick();
      check_a_flags($sformatf("fill%0d", i), i);
      check($sformatf("fill%0d.ovf", i), 32'(ovf_a), 32'h0);
    end

    // 17th write is rejected
    din_a = 8'h77;
    tick();
    check("ovf.pulse", 32'(ovf_a), 32'h1);
    check_a_flags("ovf", 16);
    we_a = 1'b0;
    tick();
    check("ovf.clear", 32'(ovf_a), 32'h0);
    check("ovf.dout",  32'(dout_a), 32'h0);

    // Full with simultaneous write and read
    we_a  = 1'b1;
    re_a  = 1'b1;
    din_a = 8'hAA;
    tick();
    check("fullwr.dout", 32'(dout_a), 32'h01);
    check("fullwr.ovf",  32'(ovf_a),  32'h0);
    check_a_flags("fullwr", 16);
    we_a = 1'b0;

    // Drain: 0x02..0x10 then 0xAA
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("drain%0d.dout", k), 32'(dout_a), (k < 16) ? 32'(k + 1) : 32'hAA);
      check_a_flags($sformatf("drain%0d", k), 16 - k);
    end

    // Read while empty
    tick();
    check("emptyrd.unf",  32'(unf_a),  32'h1);
    check("emptyrd.dout", 32'(dout_a), 32'hAA);
    check_a_flags("emptyrd", 0);
    re_a = 1'b0;
    tick();
    check("emptyrd.clear", 32'(unf_a), 32'h0);

    // Empty with simultaneous write and read
    we_a  = 1'b1;
    re_a  = 1'b1;
    din_a = 8'h55;
    tick();
    check("emptywr.unf",  32'(unf_a),  32'h1);
    check("emptywr.dout", 32'(dout_a), 32'hAA);
    check_a_flags("emptywr", 1);
    we_a = 1'b0;
    tick();
    check("emptywr.rd", 32'(dout_a), 32'h55);
    check("emptywr.unf2", 32'(unf_a), 32'h0);
    check_a_flags("emptywr.rd", 0);
    re_a = 1'b0;

    // Mid-stream asynchronous reset with count = 5
    for (int i = 0; i < 5; i++) begin
      we_a  = 1'b1;
      din_a = DW_A'(8'h31 + i);
      tick();
    end
    we_a = 1'b0;
    check("prerst.count", 32'(cnt_a), 32'd5);
    #1;
    rst_a = 1'b1;
    #1;
    check_a_flags("asyncrst", 0);
    check("asyncrst.dout", 32'(dout_a), 32'h0);
    check("asyncrst.ovf",  32'(ovf_a),  32'h0);
    check("asyncrst.unf",  32'(unf_a),  32'h0);
    tick();
    rst_a = 1'b0;
    re_a  = 1'b1;
    tick();
    check("postrst.unf",  32'(unf_a),  32'h1);
    check("postrst.dout", 32'(dout_a), 32'h0);
    check_a_flags("postrst", 0);
    re_a = 1'b0;

    // Randomised traffic on the 4-deep instance against a reference queue
    exp_dout_b = '0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      int unsigned pw;
      logic        w, r, wa_m, ra_m;
      pw    = ((cyc / 20) % 2 == 0) ? 75 : 30;
      w     = ($urandom_range(0, 99) < pw);
      r     = ($urandom_range(0, 99) < (100 - pw));
      we_b  = w;
      re_b  = r;
      din_b = DW_B'($urandom_range(0, 4095));
      wa_m  = w && ((q.size() < DP_B) || r);
      ra_m  = r && (q.size() > 0);
      if (ra_m) exp_dout_b = q.pop_front();
      if (wa_m) q.push_back(din_b);
      tick();
      check($sformatf("rnd%0d.dout", cyc),  32'(dout_b), 32'(exp_dout_b));
      check($sformatf("rnd%0d.count", cyc), 32'(cnt_b),  32'(q.size()));
      check($sformatf("rnd%0d.full", cyc),  32'(full_b), 32'(q.size() == DP_B));
      check($sformatf("rnd%0d.empty", cyc), 32'(empty_b), 32'(q.size() == 0));
      check($sformatf("rnd%0d.af", cyc),    32'(af_b),   32'(q.size() >= AF_B));
      check($sformatf("rnd%0d.ae", cyc),    32'(ae_b),   32'(q.size() <= AE_B));
      check($sformatf("rnd%0d.ovf", cyc),   32'(ovf_b),  32'(w && !wa_m));
      check($sformatf("rnd%0d.unf", cyc),   32'(unf_b),  32'(r && !ra_m));
    end
    we_b = 1'b0;
    re_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fifo_sync_param
